// File: rtl/mem_arb2_rr.sv
// mem_arb2_rr: two-requester round-robin memory arbiter with lock support
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   reqN_valid/addr/wdata/wstrb/lock  requester N transaction (wstrb==0 means read)
//   reqN_ready/rdata                  requester N completion and read data
//   mem_valid/addr/wdata/wstrb        downstream request
//   mem_ready/rdata                   downstream completion and read data
//   owner                             currently or last granted requester
module mem_arb2_rr #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_wdata,
  input  logic [DW/8-1:0] req0_wstrb,
  input  logic            req0_lock,
  output logic            req0_ready,
  output logic [DW-1:0]   req0_rdata,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_wdata,
  input  logic [DW/8-1:0] req1_wstrb,
  input  logic            req1_lock,
  output logic            req1_ready,
  output logic [DW-1:0]   req1_rdata,
  output logic            mem_valid,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            owner
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t state, state_nx;
  logic lock_held, lock_idx;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= 1'b1;
      lock_held <= 1'b0;
      lock_idx  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) owner <= state_nx == BUSY1;
      if (state != IDLE && mem_ready) begin
        lock_held <= state == BUSY1 ? req1_lock : req0_lock;
        lock_idx  <= state == BUSY1;
      end
    end
  end
  // A held lock grants only its holder, even while the holder is not requesting.
  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (lock_held)
        state_nx = lock_idx ? (req1_valid ? BUSY1 : IDLE) : (req0_valid ? BUSY0 : IDLE);
      else if (req0_valid && req1_valid)
        state_nx = owner ? BUSY0 : BUSY1;
      else
        state_nx = req0_valid ? BUSY0 : (req1_valid ? BUSY1 : IDLE);
    end else if (mem_ready) begin
      state_nx = IDLE;
    end
  end
  // Ready is gated by resetn so a transaction abandoned by reset never completes.
  always_comb begin
    mem_valid  = state != IDLE;
    mem_addr   = state == BUSY1 ? req1_addr  : (state == BUSY0 ? req0_addr  : '0);
    mem_wdata  = state == BUSY1 ? req1_wdata : (state == BUSY0 ? req0_wdata : '0);
    mem_wstrb  = state == BUSY1 ? req1_wstrb : (state == BUSY0 ? req0_wstrb : '0);
    req0_ready = resetn && state == BUSY0 && mem_ready;
    req1_ready = resetn && state == BUSY1 && mem_ready;
    req0_rdata = req0_ready ? mem_rdata : '0;
    req1_rdata = req1_ready ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_arb2_rr.sv
module tb_mem_arb2_rr;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic [3:0]  req0_wstrb = '0, req1_wstrb = '0;
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rdata, req1_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        owner;
  int checks = 0;
  int errors = 0;

  mem_arb2_rr #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_wstrb(req0_wstrb), .req0_lock(req0_lock), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_wstrb(req1_wstrb), .req1_lock(req1_lock), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_lock = 1'b0; req1_lock = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    step;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b exp 1", owner); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
    checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin errors++; $display("FAIL reset_mem_fields got %h exp 0", {mem_addr, mem_wdata, mem_wstrb}); end
    checks++; if ({req0_ready, req1_ready, req0_rdata, req1_rdata} !== 66'd0) begin errors++; $display("FAIL reset_req_outs got %h exp 0", {req0_ready, req1_ready, req0_rdata, req1_rdata}); end
  endtask

  task automatic test_single_read;
    req0_valid = 1'b1; req0_addr = 32'h1000; req0_wstrb = 4'h0;
    step;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL read_mem_valid got %b exp 1", mem_valid); end
    checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL read_mem_addr got %h exp 00001000", mem_addr); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL read_mem_wstrb got %h exp 0", mem_wstrb); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL read_owner got %b exp 0", owner); end
    for (int i = 0; i < 2; i++) begin
      step;
      checks++; if (req0_ready !== 1'b0 || mem_valid !== 1'b1) begin errors++; $display("FAIL read_wait%0d ready %b valid %b exp 0 1", i, req0_ready, mem_valid); end
    end
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL read_ready got %b exp 1", req0_ready); end
    checks++; if (req0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", req0_rdata); end
    checks++; if (req1_ready !== 1'b0 || req1_rdata !== 32'h0) begin errors++; $display("FAIL read_other got %b %h exp 0 0", req1_ready, req1_rdata); end
    step;
    req0_valid = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || req0_ready !== 1'b0 || req0_rdata !== 32'h0) begin errors++; $display("FAIL read_after valid %b ready %b rdata %h exp 0 0 0", mem_valid, req0_ready, req0_rdata); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL read_owner_hold got %b exp 0", owner); end
  endtask

  task automatic test_tie_round_robin;
    logic g;
    do_reset;
    req0_valid = 1'b1; req0_addr = 32'hA0; req1_valid = 1'b1; req1_addr = 32'hB0;
    for (int i = 0; i < 8; i++) begin
      g = i[0];
      step;
      checks++; if (owner !== g || mem_valid !== 1'b1) begin errors++; $display("FAIL tie_grant%0d owner %b valid %b exp %b 1", i, owner, mem_valid, g); end
      checks++; if (mem_addr !== (g ? 32'hB0 : 32'hA0)) begin errors++; $display("FAIL tie_addr%0d got %h exp %h", i, mem_addr, g ? 32'hB0 : 32'hA0); end
      mem_ready = 1'b1; mem_rdata = 32'h100 + i;
      #1;
      checks++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_ready%0d got %b exp %b", i, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01); end
      step;
      mem_ready = 1'b0;
      #1;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL tie_idle%0d got %b exp 0", i, mem_valid); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
  endtask

  task automatic test_lock;
    do_reset;
    req1_valid = 1'b1; req1_lock = 1'b1; req1_addr = 32'h3000;
    step;
    checks++; if (owner !== 1'b1 || mem_addr !== 32'h3000) begin errors++; $display("FAIL lock_first owner %b addr %h exp 1 00003000", owner, mem_addr); end
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0; req1_valid = 1'b0; req0_valid = 1'b1; req0_addr = 32'h4000;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL lock_block%0d valid %b exp 0", i, mem_valid); end
    end
    req1_valid = 1'b1; req1_lock = 1'b0;
    step;
    checks++; if (owner !== 1'b1 || mem_addr !== 32'h3000) begin errors++; $display("FAIL lock_regrant owner %b addr %h exp 1 00003000", owner, mem_addr); end
    mem_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL lock_ready got %b exp 10", {req1_ready, req0_ready}); end
    step;
    mem_ready = 1'b0; req1_valid = 1'b0;
    step;
    checks++; if (owner !== 1'b0 || mem_addr !== 32'h4000) begin errors++; $display("FAIL lock_release owner %b addr %h exp 0 00004000", owner, mem_addr); end
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0; req0_valid = 1'b0;
    step;
  endtask

  task automatic test_write;
    do_reset;
    req1_valid = 1'b1; req1_addr = 32'h2000; req1_wdata = 32'hA5A5A5A5; req1_wstrb = 4'b0011;
    step;
    checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_wdata got %h exp a5a5a5a5", mem_wdata); end
    checks++; if (mem_wstrb !== 4'b0011) begin errors++; $display("FAIL wr_wstrb got %b exp 0011", mem_wstrb); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL wr_req0_ready got %b exp 0", req0_ready); end
    mem_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready got %b%b exp 10", req1_ready, req0_ready); end
    step;
    mem_ready = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin errors++; $display("FAIL wr_idle_fields %h %b exp 0 0", mem_wdata, mem_wstrb); end
  endtask

  task automatic test_valid_drop;
    req0_valid = 1'b1; req0_addr = 32'h5000;
    step;
    req0_valid = 1'b0;
    step;
    step;
    checks++; if (mem_valid !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL drop_stay valid %b owner %b exp 1 0", mem_valid, owner); end
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req0_valid = 1'b1; req0_addr = 32'h6000;
    step;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", mem_valid); end
    resetn = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h12345678; req0_valid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0 || req0_rdata !== 32'h0) begin errors++; $display("FAIL rmid_ready got %b %h exp 0 0", req0_ready, req0_rdata); end
    step;
    resetn = 1'b1; mem_ready = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || owner !== 1'b1) begin errors++; $display("FAIL rmid_after valid %b owner %b exp 0 1", mem_valid, owner); end
  endtask

  task automatic test_stray_ready;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++; if ({mem_valid, req0_ready, req1_ready} !== 3'b000) begin errors++; $display("FAIL stray%0d got %b exp 000", i, {mem_valid, req0_ready, req1_ready}); end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_tie_round_robin;
    test_lock;
    test_write;
    test_valid_drop;
    test_reset_mid;
    test_stray_ready;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arb2_rr.md
MEM_ARB2_RR -- requirements
Module: mem_arb2_rr

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; byte strobe width is DW/8.
REQ-003 clk  input  1  system clock, all state updates on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester N has a transaction pending.
REQ-006 req0_addr / req1_addr  input  AW  transaction address.
REQ-007 req0_wdata / req1_wdata  input  DW  write data.
REQ-008 req0_wstrb / req1_wstrb  input  DW/8  byte write strobes; all-zero means read.
REQ-009 req0_lock / req1_lock  input  1  keep ownership after this transaction (AMO/LR-SC sequences).
REQ-010 req0_ready / req1_ready  output  1  transaction of requester N completes this cycle.
REQ-011 req0_rdata / req1_rdata  output  DW  read data, valid when the matching ready is high.
REQ-012 mem_valid  output  1  downstream request.
REQ-013 mem_addr / mem_wdata / mem_wstrb  output  AW / DW / DW/8  downstream request fields.
REQ-014 mem_ready  input  1  downstream completion.
REQ-015 mem_rdata  input  DW  downstream read data.
REQ-016 owner  output  1  index of the currently or last granted requester.

Function
REQ-017 FSM states IDLE, BUSY0, BUSY1; transitions occur only on the rising edge of clk.
REQ-018 IDLE, no valid request: remain in IDLE.
REQ-019 IDLE, exactly one reqN_valid: go to BUSYN.
REQ-020 IDLE, both valid, no lock held: grant the requester that is not `owner` (round-robin); `owner` updates to the granted index.
REQ-021 IDLE, lock held by requester L: grant only L; the other requester waits even if L is not requesting.
REQ-022 BUSYN: mem_valid=1; mem_addr/wdata/wstrb driven from requester N's inputs.
REQ-023 Requester inputs stay stable while valid is high until its ready; the arbiter does not register them.
REQ-024 BUSYN with mem_ready=1: reqN_ready=1 combinationally in the same cycle; next state IDLE.
REQ-025 BUSYN with mem_ready=0: remain in BUSYN; no cycle limit.
REQ-026 reqN_rdata = mem_rdata when reqN_ready=1, else zero; the non-owner's ready and rdata are always 0.
REQ-027 IDLE: mem_valid=0; mem_addr, mem_wdata, mem_wstrb = 0.
REQ-028 Latency: grant one cycle after valid is seen in IDLE; minimum 2 cycles from valid to ready; one IDLE cycle between back-to-back transactions.
REQ-029 Lock register: on completion in BUSYN, set lock-held-by-N if reqN_lock=1, else clear.
REQ-030 reqN_valid deasserted in BUSYN before ready is a protocol violation; the arbiter stays in BUSYN.
REQ-031 mem_ready while IDLE is ignored; no ready is generated.

Reset
REQ-032 resetn=0 at a clock edge: state=IDLE, owner=1 (so requester 0 wins the first tie), lock cleared.
REQ-033 After that edge, outputs are mem_valid=0, mem_addr/wdata/wstrb=0, both ready=0, both rdata=0.
REQ-034 Reset mid-transaction (BUSYx) abandons the transaction: no ready is issued, and the in-flight mem_ready is ignored.

Verification
REQ-035 Single read: req0_valid, addr=0x1000, wstrb=0; mem_ready 3 cycles after mem_valid with rdata=0xDEADBEEF -> req0_ready one cycle, req0_rdata=0xDEADBEEF, owner=0.
REQ-036 Tie after reset: both valid in the same cycle -> req0 granted first, then req1; alternation 0,1,0,1 over 4 back-to-back pairs.
REQ-037 Lock: req1 with lock=1, then req0 and req1 both valid -> req1 granted again; req1 completes with lock=0 -> req0 granted next.
REQ-038 Write pass-through: req1 wdata=0xA5A5A5A5, wstrb=4'b0011 -> mem_wdata/mem_wstrb match exactly while mem_valid=1; req0_ready stays 0.
REQ-039 Reset in BUSY0 with mem_ready asserted on the same edge -> no req0_ready; IDLE afterward; mem_valid=0.
REQ-040 Stray mem_ready=1 in IDLE for 5 cycles -> no ready outputs; state stays IDLE.
